narnet_forecast_seq: RTL and testbench
======================================

Name: narnet_forecast_seq

Overview:
- Sequencer that sits directly upstream of the NARNet core and drives its x_in/x_ready inputs; it also consumes the core's y_out/out_ready results.
- Priming phase: streams P measured samples into the core, one inference per sample, to fill the tap-delay line.
- Closed-loop phase: feeds each prediction back as the next input to produce H multi-step forecasts.
- Forecasts are buffered in a small output FIFO with a valid/ready drain.

Parameters:
- N, 16, sample/prediction word width (signed fixed point, same format as core).
- Q, 10, fractional bits (no arithmetic performed; kept for format consistency).
- CNT_W, 10, width of prime_len/horizon and internal step counters.
- FIFO_DEPTH, 8, forecast FIFO entries (power of 2, >=2).
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request, sampled in IDLE only.
- prime_len  in  CNT_W  P, number of measured samples; latched on accepted start.
- horizon  in  CNT_W  H, number of forecasts; latched on accepted start.
- s_data  in  N  measured sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  sample accepted when s_valid&&s_ready.
- net_clr  out  1  one-cycle active-high clear to core (reinitialises tap delays).
- net_x  out  N  sample to core.
- net_x_ready  out  1  one-cycle pulse that launches a core inference.
- net_y  in  N  core prediction.
- net_y_ready  in  1  core result pulse.
- f_data  out  N  forecast FIFO head.
- f_valid  out  1  FIFO non-empty.
- f_ready  in  1  pop when f_valid&&f_ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run end.
- err  out  1  sticky timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0. Reset asserted mid-run aborts immediately, discards FIFO contents and issues no done pulse.
- States:
  - IDLE: on start with P>0 and H>0, latch P and H, go to CLR.
  - IDLE, start with P==0 or H==0: done pulse next cycle, no core activity.
  - IDLE: start while busy is ignored.
  - CLR: net_clr=1 for one cycle, then go to PRIME_IN.
  - PRIME_IN: s_ready=1 only when (FIFO not full or not last sample). On accept, net_x<=s_data, go to ISSUE.
  - ISSUE: net_x_ready=1 for exactly one cycle, then go to WAIT. net_x stays stable from ISSUE until net_y_ready.
  - WAIT: hold until net_y_ready. Results from priming samples 1..P-1 are discarded; go to PRIME_IN. Result from sample P is forecast #1: push it to the FIFO, latch it as feedback, go to FC.
  - FC: if forecasts produced == H, go to DONE. Otherwise, when FIFO not full: net_x<=feedback, go to ISSUE. WAIT then pushes the result, updates feedback and returns to FC.
  - DONE: done=1 for one cycle, go to IDLE. The FIFO may still hold data and drains independently.
- Total core inferences per run = P+H-1. Exactly H FIFO pushes.
- Issue is allowed only when the coming result has guaranteed space: FIFO not full at issue time. Only pops can occur in between, so no push is ever dropped.
- FIFO: simultaneous push and pop when full or empty is legal. Count is unchanged when both occur. Pop on empty is ignored. f_data is registered head, valid the same cycle as f_valid.
- net_y_ready outside WAIT is ignored.
- No arithmetic on samples; values pass bit-exact.

Optional Feature:
- NARNET_FSEQ_TIMEOUT_EN defined:
  - In WAIT, an 8-bit-or-wider counter counts cycles.
  - Reaching TIMEOUT without net_y_ready sets err (sticky until reset or next accepted start), skips the remaining steps, and goes to DONE.
- Not defined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- P=3, H=2, samples 0x0100, 0x0200, 0x0300, core model returns x+0x0010: 4 net_x_ready pulses with net_x = 0x0100, 0x0200, 0x0300, 0x0310. FIFO yields 0x0310, 0x0320. One done pulse.
- P=1, H=10, FIFO_DEPTH=8, f_ready=0: 8 forecasts pushed, then no further net_x_ready. Raise f_ready: remaining 2 forecasts issue, 10 total, in order.
- s_valid toggling every other cycle during priming: each sample is launched exactly once. net_clr pulses once at run start.
- start with H=0: done the cycle after start, busy stays 0, no net_clr or net_x_ready.
- Drive rst low during WAIT with 3 entries in FIFO: all outputs 0 asynchronously, f_valid=0, no done. A subsequent run behaves normally.
- With NARNET_FSEQ_TIMEOUT_EN, TIMEOUT=20, core never responds: err=1 and done after 20 WAIT cycles. The next accepted start clears err.

Source files
------------

// File: rtl/narnet_forecast_seq.sv
`default_nettype none
// ============================================================================
// Module   : narnet_forecast_seq
// Purpose  : Sequencer in front of the NARNet core. Streams P measured samples
//            through the core to fill its tap-delay line, then feeds each
//            prediction back to produce H closed-loop forecasts, which are
//            buffered in a small valid/ready FIFO.
// Option   : NARNET_FSEQ_TIMEOUT_EN - adds a WAIT-state watchdog that sets the
//            sticky err flag and ends the run if the core stops answering.
// Revision : 1.0 - initial release
// ============================================================================
module narnet_forecast_seq #(
   parameter int N          = 16,
   parameter int Q          = 10,
   parameter int CNT_W      = 10,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] prime_len,
   input  logic [CNT_W-1:0] horizon,
   input  logic [N-1:0]     s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             net_clr,
   output logic [N-1:0]     net_x,
   output logic             net_x_ready,
   input  logic [N-1:0]     net_y,
   input  logic             net_y_ready,
   output logic [N-1:0]     f_data,
   output logic             f_valid,
   input  logic             f_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   // Q only documents the fixed-point format; samples pass through untouched.
   if (Q >= N || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("narnet_forecast_seq: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLR      = 3'd1,
      S_PRIME_IN = 3'd2,
      S_ISSUE    = 3'd3,
      S_WAIT     = 3'd4,
      S_FC       = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] p_len, h_len, prime_cnt, fc_cnt;
   logic [N-1:0]     feedback;
   logic             zero_done;
   logic             accept, push, load_fb, pop, do_push, full, last_sample;
   logic [N-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;

   assign full        = (count == FULL_CNT);
   assign last_sample = ((prime_cnt + CNT_W'(1)) == p_len);
   assign f_valid     = (count != '0);
   assign f_data      = mem[rd_ptr];
   assign pop         = f_valid && f_ready;
   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign do_push     = push && (!full || pop);

`ifdef NARNET_FSEQ_TIMEOUT_EN
   localparam int    WT_W = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;
   logic [WT_W-1:0]  wait_cnt;
   logic             timeout_hit;
   logic             err_flag;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      next_state  = state;
      net_clr     = 1'b0;
      net_x_ready = 1'b0;
      s_ready     = 1'b0;
      accept      = 1'b0;
      push        = 1'b0;
      load_fb     = 1'b0;
      busy        = (state != S_IDLE);
      done        = (state == S_DONE) || zero_done;
`ifdef NARNET_FSEQ_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         S_IDLE: if (start && prime_len != '0 && horizon != '0) next_state = S_CLR;
         S_CLR: begin
            net_clr    = 1'b1;
            next_state = S_PRIME_IN;
         end
         S_PRIME_IN: begin
            // The last sample yields forecast #1, so it needs a free FIFO slot.
            s_ready = !full || !last_sample;
            if (s_valid && s_ready) begin
               accept     = 1'b1;
               next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            net_x_ready = 1'b1;
            next_state  = S_WAIT;
         end
         S_WAIT: begin
            if (net_y_ready) begin
               if (prime_cnt != p_len) begin
                  next_state = S_PRIME_IN;
               end else begin
                  push       = 1'b1;
                  next_state = S_FC;
               end
            end
`ifdef NARNET_FSEQ_TIMEOUT_EN
            else if (wait_cnt == WT_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               next_state  = S_DONE;
            end
`endif
         end
         S_FC: begin
            if (fc_cnt == h_len) begin
               next_state = S_DONE;
            end else if (!full) begin
               load_fb    = 1'b1;
               next_state = S_ISSUE;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Run parameters, step counters and the sample/feedback path to the core.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_len     <= '0;
         h_len     <= '0;
         prime_cnt <= '0;
         fc_cnt    <= '0;
         feedback  <= '0;
         net_x     <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= 1'b0;
         if (state == S_IDLE && start) begin
            if (prime_len == '0 || horizon == '0) begin
               zero_done <= 1'b1;
            end else begin
               p_len     <= prime_len;
               h_len     <= horizon;
               prime_cnt <= '0;
               fc_cnt    <= '0;
            end
         end
         if (accept) begin
            net_x     <= s_data;
            prime_cnt <= prime_cnt + CNT_W'(1);
         end
         if (push) begin
            feedback <= net_y;
            fc_cnt   <= fc_cnt + CNT_W'(1);
         end
         if (load_fb) net_x <= feedback;
      end
   end

   // Forecast FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= net_y;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef NARNET_FSEQ_TIMEOUT_EN
   // Watchdog: counts WAIT cycles; err is sticky until the next start request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         err_flag <= 1'b0;
      end else begin
         wait_cnt <= (state == S_WAIT) ? wait_cnt + WT_W'(1) : '0;
         if (state == S_IDLE && start) err_flag <= 1'b0;
         else if (timeout_hit)         err_flag <= 1'b1;
      end
   end
   assign err = err_flag;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_narnet_forecast_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_narnet_forecast_seq
// Purpose  : Self-checking bench for narnet_forecast_seq with a behavioural
//            core, sample source and FIFO drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_narnet_forecast_seq;
   localparam int N     = 16;
   localparam int CNT_W = 10;

   logic             clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [CNT_W-1:0] prime_len = '0, horizon = '0;
   logic [N-1:0]     s_data = '0, net_y = '0;
   logic             s_valid = 1'b0, net_y_ready = 1'b0, f_ready = 1'b0;
   logic             s_ready, net_clr, net_x_ready, f_valid, busy, done, err;
   logic [N-1:0]     net_x, f_data;

   narnet_forecast_seq #(.N(N), .Q(10), .CNT_W(CNT_W), .FIFO_DEPTH(8), .TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .start(start), .prime_len(prime_len), .horizon(horizon),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .net_clr(net_clr),
      .net_x(net_x), .net_x_ready(net_x_ready), .net_y(net_y), .net_y_ready(net_y_ready),
      .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   logic [N-1:0] smp[$], src_q[$], launches[$], got[$];
   logic [N-1:0] core_add = '0, tmp, cx;
   int  vmode = 0, fmode = 0, lat_min = 1, lat_max = 1, gen = 0, g;
   int  clr_cnt = 0, done_cnt = 0;
   bit  busy_seen = 0, core_on = 1, tgl = 0;

   typedef struct {
      int p; int h; logic [N-1:0] base; logic [N-1:0] step; logic [N-1:0] add;
      int vm; int fm; int lat; int exp_inf;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Sample source: presents queued samples according to vmode.
   always begin
      @(negedge clk);
      tgl = ~tgl;
      if (src_q.size() != 0 && (vmode == 0 || (vmode == 1 && tgl) ||
                                (vmode == 2 && $urandom_range(1, 0) == 1))) begin
         s_valid = 1'b1;
         s_data  = src_q[0];
      end else begin
         s_valid = 1'b0;
      end
      if (s_valid && s_ready) tmp = src_q.pop_front();
   end

   // FIFO drain: 0 = always ready, 1 = random, 2 = held off.
   always begin
      @(negedge clk);
      f_ready = (fmode == 0) || (fmode == 1 && $urandom_range(1, 0) == 1);
      if (f_valid && f_ready) got.push_back(f_data);
   end

   // Event monitor.
   always begin
      @(negedge clk);
      if (net_clr)     clr_cnt++;
      if (done)        done_cnt++;
      if (busy)        busy_seen = 1'b1;
      if (net_x_ready) launches.push_back(net_x);
   end

   // Behavioural core: y = x + core_add after a random latency.
   always begin
      @(negedge clk);
      if (net_x_ready && core_on) begin
         cx = net_x;
         g  = gen;
         repeat ($urandom_range(lat_max, lat_min)) @(negedge clk);
         if (g == gen) begin
            chk("net_x held until result", net_x, cx);
            net_y       = cx + core_add;
            net_y_ready = 1'b1;
            @(negedge clk);
            net_y_ready = 1'b0;
         end
      end
   end

   task automatic start_run(input int p, input int h);
      @(negedge clk);
      prime_len = CNT_W'(p);
      horizon   = CNT_W'(h);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run(input int p, input int h, input int exp_inf, input string tag);
      logic [N-1:0] exp_l[$];
      logic [N-1:0] exp_f[$];
      logic [N-1:0] y;
      int t;
      // Reference: all P samples go in, then each forecast is fed back.
      for (int i = 0; i < p; i++) exp_l.push_back(smp[i]);
      y = smp[p-1] + core_add;
      exp_f.push_back(y);
      for (int k = 1; k < h; k++) begin
         exp_l.push_back(y);
         y = y + core_add;
         exp_f.push_back(y);
      end
      launches.delete(); got.delete();
      clr_cnt = 0; done_cnt = 0;
      src_q = smp;
      start_run(p, h);
      repeat (4) @(negedge clk);
      if (busy) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while ((done_cnt == 0 || got.size() < h) && t < 3000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk($sformatf("%s done pulses", tag), done_cnt, 1);
      chk($sformatf("%s clr pulses", tag), clr_cnt, 1);
      chk($sformatf("%s err", tag), err, 0);
      chk($sformatf("%s inferences", tag), launches.size(), exp_inf);
      chk($sformatf("%s forecasts", tag), got.size(), h);
      for (int i = 0; i < exp_l.size(); i++)
         chk($sformatf("%s net_x[%0d]", tag, i),
             (i < launches.size()) ? 32'(launches[i]) : 32'hdeadbeef, 32'(exp_l[i]));
      for (int i = 0; i < h; i++)
         chk($sformatf("%s f_data[%0d]", tag, i),
             (i < got.size()) ? 32'(got[i]) : 32'hdeadbeef, 32'(exp_f[i]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      tbl[0] = '{3, 2,  16'h0100, 16'h0100, 16'h0010, 0, 0, 1, 4};
      tbl[1] = '{4, 3,  16'h8000, 16'h1234, 16'hfff0, 1, 0, 2, 6};
      tbl[2] = '{2, 9,  16'h7ff0, 16'h0001, 16'h0003, 2, 1, 3, 10};
      tbl[3] = '{1, 1,  16'h5555, 16'h0000, 16'h1111, 0, 1, 1, 1};

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset ctl", {busy, f_valid, s_ready, net_x_ready, net_clr, done, err}, 0);
      chk("reset net_x", net_x, 0);
      chk("reset f_data", f_data, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-length requests: done next cycle, no core activity.
      for (int z = 0; z < 2; z++) begin
         busy_seen = 0; clr_cnt = 0; launches.delete();
         @(negedge clk);
         prime_len = (z == 0) ? CNT_W'(3) : CNT_W'(0);
         horizon   = (z == 0) ? CNT_W'(0) : CNT_W'(4);
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("zero%0d done next cycle", z), done, 1);
         @(negedge clk);
         chk($sformatf("zero%0d done single", z), done, 0);
         repeat (3) @(negedge clk);
         chk($sformatf("zero%0d busy", z), busy_seen, 0);
         chk($sformatf("zero%0d clr", z), clr_cnt, 0);
         chk($sformatf("zero%0d launches", z), launches.size(), 0);
      end

      // Backpressure: P=1, H=10 with the drain held off.
      core_add = 16'h0001; vmode = 0; fmode = 2; lat_min = 1; lat_max = 2;
      smp.delete(); smp.push_back(16'h0040);
      launches.delete(); got.delete(); done_cnt = 0; src_q = smp;
      start_run(1, 10);
      t = 0;
      while (launches.size() < 8 && t < 500) begin @(negedge clk); t++; end
      repeat (30) @(negedge clk);
      chk("hold inferences", launches.size(), 8);
      chk("hold f_valid", f_valid, 1);
      chk("hold busy", busy, 1);
      chk("hold done", done_cnt, 0);
      fmode = 0;
      t = 0;
      while ((done_cnt == 0 || got.size() < 10) && t < 500) begin @(negedge clk); t++; end
      chk("hold total inferences", launches.size(), 10);
      chk("hold total forecasts", got.size(), 10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("hold f_data[%0d]", i),
             (i < got.size()) ? 32'(got[i]) : 32'hdeadbeef, 32'h41 + 32'(i));

      // Full FIFO left from a previous run blocks only the last priming sample.
      fmode = 2; smp.delete(); smp.push_back(16'h0200);
      launches.delete(); got.delete(); done_cnt = 0; src_q = smp;
      start_run(1, 8);
      t = 0;
      while (done_cnt == 0 && t < 500) begin @(negedge clk); t++; end
      smp.delete(); smp.push_back(16'ha000); smp.push_back(16'hb000);
      src_q = smp; launches.delete();
      start_run(2, 1);
      repeat (40) @(negedge clk);
      chk("full-last inferences", launches.size(), 1);
      chk("full-last s_ready", s_ready, 0);
      fmode = 0;
      t = 0;
      while ((done_cnt < 2 || got.size() < 9) && t < 500) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk("full-last drained", got.size(), 9);
      chk("full-last old head", (got.size() > 0) ? 32'(got[0]) : 32'hdeadbeef, 32'h0201);
      chk("full-last new tail", (got.size() > 8) ? 32'(got[8]) : 32'hdeadbeef, 32'hb001);

      // Reset in WAIT with three forecasts buffered.
      fmode = 2; lat_min = 20; lat_max = 20;
      smp.delete(); smp.push_back(16'h0300);
      launches.delete(); got.delete(); done_cnt = 0; src_q = smp;
      start_run(1, 6);
      t = 0;
      while (launches.size() < 4 && t < 500) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("pre-reset f_valid", f_valid, 1);
      #2 rst = 1'b0; gen++;
      #1;
      chk("async reset ctl", {busy, f_valid, s_ready, net_x_ready, net_clr, done, err}, 0);
      chk("async reset f_data", f_data, 0);
      chk("async reset net_x", net_x, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1; fmode = 0; lat_min = 1; lat_max = 2;
      repeat (25) @(negedge clk);
      chk("post-reset done", done_cnt, 0);
      chk("post-reset f_valid", f_valid, 0);
      chk("post-reset drained nothing", got.size(), 0);

`ifdef NARNET_FSEQ_TIMEOUT_EN
      // Core never answers: watchdog ends the run with err set.
      core_on = 0; smp.delete(); smp.push_back(16'h0123);
      launches.delete(); done_cnt = 0; src_q = smp;
      start_run(1, 2);
      t = 0;
      while (launches.size() == 0 && t < 100) begin @(negedge clk); t++; end
      t = 0;
      while (done_cnt == 0 && t < 100) begin @(negedge clk); t++; end
      chk("timeout latency", (t >= 19 && t <= 23), 1);
      chk("timeout err", err, 1);
      core_on = 1;
`endif

      // Directed vector table.
      for (int v = 0; v < 4; v++) begin
         smp.delete();
         for (int i = 0; i < tbl[v].p; i++) smp.push_back(N'(tbl[v].base + tbl[v].step * i));
         vmode = tbl[v].vm; fmode = tbl[v].fm; core_add = tbl[v].add;
         lat_min = 1; lat_max = tbl[v].lat;
         run(tbl[v].p, tbl[v].h, tbl[v].exp_inf, $sformatf("vec%0d", v));
      end

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         int p, h;
         p = $urandom_range(5, 1);
         h = $urandom_range(12, 1);
         smp.delete();
         for (int i = 0; i < p; i++) smp.push_back(N'($urandom));
         core_add = N'($urandom);
         vmode = $urandom_range(2, 0); fmode = $urandom_range(1, 0);
         lat_min = 1; lat_max = $urandom_range(3, 1);
         run(p, h, p + h - 1, $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
